pc_next_ctrl: RTL and testbench

Program-counter sequencer for the single-cycle core; it is the producer/consumer end of the PC-select 2:1 mux.
- Generates the PC+4 operand (mux "sum" leg) and the mux select from branch/jump decode and the ALU zero flag.
- Registers the selected next PC and owns halt, stall and misaligned-target trap handling.
- Counts retired instructions.

---
 rtl/pc_next_ctrl_pkg.sv | 21 ++
 rtl/pc_next_ctrl_sat.sv | 25 ++
 rtl/pc_next_ctrl.sv | 101 ++++++++++
 tb/tb_pc_next_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_next_ctrl_pkg.sv
// Purpose: shared PC-sequencing constants and the sequencer state encoding used by
//          decode, the PC mux and pc_next_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_next_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_TRAP   = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

    // PC mux select encodings
    localparam logic SEL_SEQ = 1'b0;
    localparam logic SEL_TGT = 1'b1;

endpackage

// File: rtl/pc_next_ctrl_sat.sv
// Purpose: saturating up-counter with enable and synchronous clear.
// Latency: count visible one cycle after an enabled edge.
// Backpressure: none; en simply gates the increment, holds at all-ones.
// Ports: clk, reset (sync clear, active-high), en (increment), cnt (count).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] FULL = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en && (cnt != FULL)) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/pc_next_ctrl.sv
// Purpose: PC sequencer; drives the PC mux select and sum leg, registers next PC,
//          handles halt/stall/misaligned-target trap, counts retired instructions.
// Latency: pc updates one cycle after a decision; pc_plus4/pc_sel are combinational.
// Backpressure: stall holds pc and suppresses retire; halt freezes until reset.
// Ports: clk, reset (sync, active-high), stall, halt_req, branch, jump, alu_zero,
//        target -> pc, pc_plus4, pc_sel, misalign (sticky), halted, retired.
module pc_next_ctrl
    import pc_next_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch,
    input  logic             jump,
    input  logic             alu_zero,
    input  logic [31:0]      target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             pc_sel,
    output logic             misalign,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    pc_state_t   state;
    pc_state_t   state_nxt;
    logic [31:0] pc_nxt;
    logic        misalign_nxt;
    logic        retire;
    logic        taken;

    assign pc_plus4 = pc + PC_STEP;
    assign taken    = jump | (branch & alu_zero);
    // Only RUN steers the mux to the target; TRAP and HALTED present the sum leg.
    assign pc_sel   = (state == ST_RUN) ? taken : SEL_SEQ;
    assign halted   = (state == ST_HALTED);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        misalign_nxt = misalign;
        retire       = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt = ST_HALTED;
                end else if (stall) begin
                    state_nxt = ST_RUN;
                end else if (taken && (target[1:0] != 2'b00)) begin
                    // Misaligned taken target: vector to the trap handler, no retire.
                    state_nxt    = ST_TRAP;
                    pc_nxt       = TRAP_PC;
                    misalign_nxt = 1'b1;
                end else if (taken) begin
                    pc_nxt = target;
                    retire = 1'b1;
                end else begin
                    pc_nxt = pc_plus4;
                    retire = 1'b1;
                end
            end
            ST_TRAP: begin
                // Single bubble cycle at TRAP_PC; stall has no effect here.
                state_nxt = halt_req ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            misalign <= misalign_nxt;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_retired_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .cnt   (retired)
    );

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Purpose: self-checking bench for pc_next_ctrl (32-bit and 4-bit counter builds).
// Latency: expectations are issued per cycle and checked on the following negedge.
// Backpressure: n/a.
module tb_pc_next_ctrl;
    import pc_next_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, branch, jump, alu_zero;
    logic [31:0] target;

    logic [31:0] pc, pc_plus4, pc4, pc_plus4_4;
    logic        pc_sel, misalign, halted, pc_sel4, misalign4, halted4;
    logic [31:0] retired;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    pc_next_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .branch(branch), .jump(jump), .alu_zero(alu_zero), .target(target),
        .pc(pc), .pc_plus4(pc_plus4), .pc_sel(pc_sel), .misalign(misalign),
        .halted(halted), .retired(retired)
    );

    pc_next_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .branch(branch), .jump(jump), .alu_zero(alu_zero), .target(target),
        .pc(pc4), .pc_plus4(pc_plus4_4), .pc_sel(pc_sel4), .misalign(misalign4),
        .halted(halted4), .retired(retired4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        pc_sel;
        logic        misalign;
        logic        halted;
        logic [31:0] ret32;
        logic [3:0]  ret4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural view of the sequencer.
    logic [31:0] m_pc;
    bit          m_halt, m_trap, m_mis;
    longint      m_ret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_halt = 1'b0;
        m_trap = 1'b0;
        m_mis  = 1'b0;
        m_ret  = 0;
    endtask

    // Apply one cycle of inputs, queue what the DUT should show this cycle,
    // then advance the model across the coming edge.
    task automatic step(input bit rst, input bit st, input bit hr, input bit br,
                        input bit jp, input bit z, input logic [31:0] tg, input bit xdec);
        exp_t e;
        bit   tk;
        reset    = rst;
        stall    = st;
        halt_req = hr;
        if (xdec) begin
            branch = 1'bx; jump = 1'bx; alu_zero = 1'bx; target = 'x;
        end else begin
            branch = br; jump = jp; alu_zero = z; target = tg;
        end
        tk         = jp | (br & z);
        e.pc       = m_pc;
        e.pc_plus4 = m_pc + 32'd4;
        e.pc_sel   = (!m_halt && !m_trap) ? tk : 1'b0;
        e.misalign = m_mis;
        e.halted   = m_halt;
        e.ret32    = m_ret[31:0];
        e.ret4     = (m_ret > 15) ? 4'hF : m_ret[3:0];
        sb_q.push_back(e);

        if (rst) begin
            model_reset();
        end else if (m_halt) begin
            // frozen
        end else if (m_trap) begin
            m_trap = 1'b0;
            if (hr) m_halt = 1'b1;
        end else if (hr) begin
            m_halt = 1'b1;
        end else if (st) begin
            // hold
        end else if (tk && (tg % 4 != 0)) begin
            m_pc   = 32'h100;
            m_trap = 1'b1;
            m_mis  = 1'b1;
        end else if (tk) begin
            m_pc  = tg;
            m_ret = m_ret + 1;
        end else begin
            m_pc  = m_pc + 32'd4;
            m_ret = m_ret + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc",        pc,                 e.pc);
                chk("pc_plus4",  pc_plus4,           e.pc_plus4);
                chk("pc_sel",    {31'b0, pc_sel},    {31'b0, e.pc_sel});
                chk("misalign",  {31'b0, misalign},  {31'b0, e.misalign});
                chk("halted",    {31'b0, halted},    {31'b0, e.halted});
                chk("retired",   retired,            e.ret32);
                chk("pc_w4",     pc4,                e.pc);
                chk("retired_w4", {28'b0, retired4}, {28'b0, e.ret4});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit          rr, hh, ss, bb, jj, zz;
        logic [31:0] tt;
        reset = 1'b1; stall = 1'b0; halt_req = 1'b0;
        branch = 1'b0; jump = 1'b0; alu_zero = 1'b0; target = 32'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;

        // Sequential run from reset
        free_run(4);
        step(0, 0, 0, 0, 0, 0, 32'h0, 0);
        do_reset();
        // Taken branch at pc 8, then not-taken branch at pc 8
        free_run(2);
        step(0, 0, 0, 1, 0, 1, 32'h40, 0);
        free_run(1);
        do_reset();
        free_run(2);
        step(0, 0, 0, 1, 0, 0, 32'h40, 0);
        free_run(1);
        // Stall at pc 10 with jump ignored, then jump on release
        step(0, 1, 0, 0, 1, 0, 32'h80, 0);
        step(0, 1, 0, 0, 1, 0, 32'h80, 0);
        step(0, 1, 0, 0, 1, 0, 32'h80, 0);
        step(0, 0, 0, 0, 1, 0, 32'h80, 0);
        // Branch+jump together, jump dominates even with alu_zero low
        step(0, 0, 0, 1, 1, 0, 32'h90, 0);
        // Misaligned jump -> TRAP (stall and jump during TRAP ignored)
        step(0, 0, 0, 0, 1, 0, 32'h42, 0);
        step(0, 1, 0, 0, 1, 0, 32'h200, 0);
        free_run(2);
        // Second trap keeps misalign set
        step(0, 0, 0, 1, 0, 1, 32'h7, 0);
        free_run(1);
        // Halt at pc 20, frozen despite jumps and unknown decode
        step(0, 0, 0, 0, 1, 0, 32'h20, 0);
        step(0, 0, 1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 32'h44, (i % 3) == 2);
        do_reset();
        // Reset while stalled
        free_run(2);
        step(1, 1, 0, 0, 0, 0, 32'h0, 0);
        // Halt requested during TRAP
        step(0, 0, 0, 0, 1, 0, 32'h3, 0);
        step(0, 0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 0);
        do_reset();
        // Wrap from FFFF_FFFC, then saturate the 4-bit counter
        step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0);
        free_run(20);
        do_reset();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            rr = ($urandom_range(0, 79) == 0) || (m_halt && $urandom_range(0, 7) == 0);
            hh = ($urandom_range(0, 59) == 0);
            ss = ($urandom_range(0, 4) == 0);
            bb = $urandom_range(0, 1) == 1;
            jj = ($urandom_range(0, 3) == 0);
            zz = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       tt = $urandom;
                1:       tt = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                default: tt = $urandom & 32'h0000_0FFC;
            endcase
            step(rr, ss, hh, bb, jj, zz, tt, 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
